// File: rtl/ttl_scan_pkg.sv
// Shared definitions for the 74251 mux-scan sequencer: FSM encodings,
// settle counter width and the device-count ceiling.
package ttl_scan_pkg;

   localparam int MAX_MUX = 8;
   localparam int CNT_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } scan_state_e;

endpackage

// File: rtl/ttl_scan_timer.sv
// Settle down-counter: loaded on entry to SETTLE, flags terminal count at zero.
module ttl_scan_timer
   import ttl_scan_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ttl_mux_scan_ctrl.sv
// Scan sequencer for NUM_MUX 74251-style muxes sharing one Y line.
// Optional change detection on completed words: define SCAN_CHANGE_DET_EN.
//
// state  | meaning
// IDLE   | bus released, waiting for start
// SETTLE | device m enabled with sel=s, waiting SETTLE cycles
// SAMPLE | capture y_in into shadow bit 8*m+s
// GAP    | break-before-make: all devices off, sel=0
// DONE   | data_out updated, done pulse, bus released
module ttl_mux_scan_ctrl
   import ttl_scan_pkg::*;
#(
   parameter int NUM_MUX = 2,
   parameter int SETTLE  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 y_in,
   output logic [2:0]           sel,
   output logic [NUM_MUX-1:0]   oe_bar,
   output logic                 busy,
   output logic                 done,
   output logic [8*NUM_MUX-1:0] data_out,
   output logic                 data_vld,
   output logic                 changed
);

   localparam int               W         = 8 * NUM_MUX;
   localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
   localparam scan_state_e      ST_CODE   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [2:0]       M_LAST    = 3'(NUM_MUX - 1);

   scan_state_e        state_q, state_d;
   logic [2:0]         m_q, m_d;
   logic [2:0]         s_q, s_d;
   logic [2:0]         sel_q, sel_d;
   logic [NUM_MUX-1:0] oe_bar_q, oe_bar_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               vld_q, vld_d;
   logic [W-1:0]       shadow_q, shadow_d;
   logic [W-1:0]       data_q, data_d;
   logic [5:0]         bit_idx;
   logic               tmr_load;
   logic               tmr_tc;

   assign bit_idx  = {m_q, s_q};
   assign tmr_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

   ttl_scan_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LD),
      .en_i       (state_q == ST_SETTLE),
      .tc_o       (tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         m_q      <= '0;
         s_q      <= '0;
         sel_q    <= '0;
         oe_bar_q <= '1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         vld_q    <= 1'b0;
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         s_q      <= s_d;
         sel_q    <= sel_d;
         oe_bar_q <= oe_bar_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         vld_q    <= vld_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      s_d      = s_q;
      shadow_d = shadow_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_CODE;
               m_d     = '0;
               s_d     = '0;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tmr_tc) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            for (int i = 0; i < W; i++) begin
               if (6'(i) == bit_idx) begin
                  shadow_d[i] = y_in;
               end
            end
            if (abort) begin
               state_d = ST_IDLE;
            end else if (s_q != 3'd7) begin
               s_d     = s_q + 3'd1;
               state_d = ST_CODE;
            end else if (m_q != M_LAST) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               m_d     = m_q + 3'd1;
               s_d     = '0;
               state_d = ST_CODE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so the bus enables never glitch.
   always_comb begin
      sel_d    = '0;
      oe_bar_d = '1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      vld_d    = vld_q;
      data_d   = data_q;
      case (state_d)
         ST_SETTLE, ST_SAMPLE: begin
            sel_d  = s_d;
            busy_d = 1'b1;
            for (int i = 0; i < NUM_MUX; i++) begin
               if (3'(i) == m_d) begin
                  oe_bar_d[i] = 1'b0;
               end
            end
         end
         ST_GAP:  busy_d = 1'b1;
         ST_DONE: begin
            done_d = 1'b1;
            vld_d  = 1'b1;
            data_d = shadow_d;
         end
         default: ;
      endcase
   end

`ifdef SCAN_CHANGE_DET_EN
   logic changed_q, changed_d;

   // data_q still holds the previous completed word on the edge that replaces it.
   always_comb begin
      changed_d = (state_d == ST_DONE) && (!vld_q || (shadow_d != data_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;
`else
   assign changed = 1'b0;
`endif

   assign sel      = sel_q;
   assign oe_bar   = oe_bar_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_q;
   assign data_vld = vld_q;

endmodule
